sha256_digest_out: RTL
======================

Name: sha256_digest_out

Overview:
Back end of the SHA-256 datapath: holds the eight 32-bit chaining words H0..H7.
- Loads them with the standard initial hash values at message start.
- Folds each finished compression block's working variables into them (mod-2^32 add).
- After the last block, streams the 256-bit digest out as eight 32-bit words over a valid/ready handshake.
- Feeds the current chaining value back to the compression core for the next block.

Parameters:
H0_FIRST, 1, word order of output stream: 1 = H0..H7, 0 = H7..H0
DONE_PULSE, 1, 1 = digest_done is a 1-cycle pulse; 0 = level held until next msg_start

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
msg_start  input  1  1-cycle pulse: begin new message, reload IV
blk_done  input  1  1-cycle pulse: compression core finished a block, wv valid
last_blk  input  1  qualifies blk_done: this block is the message's last
wv  input  256  working vars {a,b,c,d,e,f,g,h}, a in [255:224]
chain_out  output  256  current {H0..H7}, H0 in [255:224]
busy  output  1  high in ACCUM or STREAM
dout  output  32  digest word
dout_valid  output  1  dout holds a valid word
dout_ready  input  1  sink accepts dout this cycle
digest_done  output  1  last digest word accepted

Behaviour:
- IV: H0..H7 = 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19.
- Reset (async, rst_n=0):
  - H = IV; state IDLE; word counter 0.
  - dout = 0, dout_valid = 0, digest_done = 0, busy = 0.
- FSM states: IDLE, ACCUM, STREAM.
- msg_start, accepted in any state, highest priority:
  - Next cycle: H = IV, state ACCUM, counter 0, dout_valid = 0, digest_done = 0.
  - Aborts an in-progress stream.
  - A simultaneous blk_done is ignored.
- blk_done in ACCUM:
  - Next cycle: H[i] = (H[i] + wv_word[i]) mod 2^32, 1-cycle latency; carries are discarded per word.
  - last_blk = 0: stay in ACCUM.
  - last_blk = 1: go to STREAM. dout_valid rises the same cycle H updates; dout = first word of the updated H.
- blk_done in IDLE or STREAM: ignored, no state change.
- STREAM:
  - dout and dout_valid are registered and must stay stable while dout_valid=1 and dout_ready=0.
  - Handshake = dout_valid & dout_ready. Each handshake advances the counter; the next word is presented the following cycle with no bubble.
  - Handshake on word index 7: next cycle dout_valid = 0, state IDLE, counter 0, digest_done asserted per DONE_PULSE.
  - H is not modified during STREAM.
- chain_out is a direct register output, always equal to H.
- busy = (state != IDLE).
- dout in IDLE/ACCUM holds its last value; it is don't-care when dout_valid = 0.

Optional Feature:
- Macro: SHA256_DIGEST_ERR_EN.
- Defined:
  - Adds output proto_err (1 bit, reset 0), sticky.
  - Set on blk_done in IDLE or STREAM, or on msg_start while in STREAM.
  - Cleared only by reset or by a msg_start issued in IDLE.
- Undefined:
  - No proto_err port.
  - Violations are silently ignored as described above.

Test Plan:
1. Reset then msg_start; blk_done+last_blk with wv=0 -> stream equals IV words 6a09e667 ... 5be0cd19 in order; digest_done pulses once after 8th accept.
2. "abc" single block: wv = 506e3058 d39a2165 04d24d6c b85e2ce9 5ef50f24 fb121210 948d25b6 961f4894 -> dout sequence ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
3. Wrap-around: wv all ffffffff, last_blk=1 -> words are IV-1 each (6a09e666, bb67ae84, ...), no carry into neighbouring words.
4. Two blocks: first blk_done with last_blk=0 and wv=0, chain_out == IV; second with "abc" wv -> same digest as test 2. Random dout_ready stalls (ready low 3 cycles on word 2) -> dout held stable, no words lost or duplicated.
5. msg_start during STREAM after 3 words accepted -> dout_valid low next cycle, chain_out == IV, no digest_done; with SHA256_DIGEST_ERR_EN proto_err = 1.
6. rst_n low mid-ACCUM (asynchronous, between clock edges) -> outputs reach reset values immediately; a following blk_done is ignored until msg_start.

Source files
------------

// File: rtl/sha256_digest_out.sv
// SHA-256 digest back end: holds chaining words H0..H7, folds each
// compression block's working variables into them, then streams the
// 256-bit digest out as eight 32-bit words over a valid/ready handshake.
// Optional macro SHA256_DIGEST_ERR_EN adds a sticky proto_err output.
module sha256_digest_out #(
  parameter bit H0_FIRST   = 1'b1,  // 1: stream H0..H7, 0: stream H7..H0
  parameter bit DONE_PULSE = 1'b1   // 1: digest_done 1-cycle pulse, 0: level
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         msg_start,
  input  logic         blk_done,
  input  logic         last_blk,
  input  logic [255:0] wv,
  output logic [255:0] chain_out,
  output logic         busy,
  output logic [31:0]  dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         digest_done
`ifdef SHA256_DIGEST_ERR_EN
  , output logic       proto_err
`endif
);

  // Packed index 7 holds H0 so the vector layout matches chain_out/wv.
  localparam logic [7:0][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [1:0] {IDLE, ACCUM, STREAM} state_t;

  state_t           state_q, state_d;
  logic [7:0][31:0] h_q, h_d, h_sum;
  logic [2:0]       cnt_q, cnt_d;
  logic [31:0]      dout_q, dout_d;
  logic             dval_q, dval_d;
  logic             done_q, done_d;
  logic             hs;

  // Word selected by stream index, honouring the configured word order.
  function automatic logic [31:0] pick(input logic [7:0][31:0] h, input logic [2:0] idx);
    return H0_FIRST ? h[3'd7 - idx] : h[idx];
  endfunction

  // Per-word mod-2^32 fold; carries never cross word boundaries.
  always_comb begin
    for (int k = 0; k < 8; k++) h_sum[k] = h_q[k] + wv[k*32 +: 32];
  end

  assign hs = dval_q & dout_ready;

  // Next-state logic: msg_start outranks everything, including blk_done.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    dval_d  = dval_q;
    done_d  = DONE_PULSE ? 1'b0 : done_q;
    if (msg_start) begin
      state_d = ACCUM;
      h_d     = IV;
      cnt_d   = 3'd0;
      dval_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (blk_done) begin
            h_d = h_sum;
            if (last_blk) begin
              state_d = STREAM;
              cnt_d   = 3'd0;
              dval_d  = 1'b1;
              dout_d  = pick(h_sum, 3'd0);
            end
          end
        end
        STREAM: begin
          if (hs) begin
            if (cnt_q == 3'd7) begin
              state_d = IDLE;
              cnt_d   = 3'd0;
              dval_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              cnt_d  = cnt_q + 3'd1;
              dout_d = pick(h_q, cnt_q + 3'd1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State, chaining value and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_q     <= IV;
      cnt_q   <= 3'd0;
      dout_q  <= 32'd0;
      dval_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dval_q  <= dval_d;
      done_q  <= done_d;
    end
  end

  assign chain_out   = h_q;
  assign busy        = (state_q != IDLE);
  assign dout        = dout_q;
  assign dout_valid  = dval_q;
  assign digest_done = done_q;

`ifdef SHA256_DIGEST_ERR_EN
  logic perr_q, perr_d;

  // Sticky protocol error; only a clean restart from IDLE clears it.
  always_comb begin
    perr_d = perr_q;
    if (msg_start) begin
      if (state_q == STREAM)    perr_d = 1'b1;
      else if (state_q == IDLE) perr_d = 1'b0;
    end else if (blk_done && state_q != ACCUM) begin
      perr_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perr_q <= 1'b0;
    else        perr_q <= perr_d;
  end

  assign proto_err = perr_q;
`endif

endmodule
